// File: rtl/meas_readout_pkg.sv
// Shared types and constants for the measurement readout SPI slave.
// MEAS_READOUT_CRC8_EN appends a CRC-8 byte to every frame.
package meas_readout_pkg;

   localparam int unsigned TAG_W            = 8;
   localparam int unsigned DATA_W           = 24;
   localparam int unsigned RECORD_WIDTH     = TAG_W + 2 * DATA_W;

   localparam int unsigned STATUS_W         = 8;
   localparam int unsigned STATUS_VALID_BIT = 7;
   localparam int unsigned STATUS_OVF_BIT   = 6;
   localparam int unsigned STATUS_LEVEL_W   = 6;
   localparam int unsigned STATUS_LEVEL_MAX = (1 << STATUS_LEVEL_W) - 1;

   localparam int unsigned BASE_FRAME_BITS  = STATUS_W + RECORD_WIDTH;
`ifdef MEAS_READOUT_CRC8_EN
   localparam int unsigned FRAME_BITS       = BASE_FRAME_BITS + 8;
`else
   localparam int unsigned FRAME_BITS       = BASE_FRAME_BITS;
`endif

   localparam logic [7:0]  CRC8_POLY        = 8'h07;

   // Bit counter saturates well above the longest frame
   localparam int unsigned BIT_CNT_W        = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data_1;
      logic [DATA_W-1:0] data_2;
   } meas_record_t;

`ifdef MEAS_READOUT_CRC8_EN
   // MSB-first CRC-8, init 0x00, no reflection, no final xor
   function automatic logic [7:0] crc8(input logic [BASE_FRAME_BITS-1:0] data);
      logic [7:0] crc;
      crc = 8'h00;
      for (int i = int'(BASE_FRAME_BITS) - 1; i >= 0; i--) begin
         if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
         else                  crc = {crc[6:0], 1'b0};
      end
      return crc;
   endfunction
`endif

endpackage

// File: rtl/meas_fifo.sv
// Synchronous show-ahead FIFO; a push is refused whenever full, even alongside a pop.
module meas_fifo #(
   parameter int unsigned WIDTH = 56,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic [LW-1:0]    count_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)      count_nxt = count + LW'(1);
      else if (!push_ok && pop_ok) count_nxt = count - LW'(1);
   end

   // Flags are registered from the next count so they are never glitchy outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == LW'(DEPTH));
         empty <= (count_nxt == LW'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign level = count;

endmodule

// File: rtl/meas_readout_spi_slave.sv
// Buffers measurement records and serves one per chip-select frame as a mode-0 SPI slave.
// Define MEAS_READOUT_CRC8_EN to append a CRC-8 byte (72-bit frames).
module meas_readout_spi_slave
   import meas_readout_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_valid,
   input  logic [TAG_WIDTH-1:0]          wr_tag,
   input  logic [DATA_WIDTH-1:0]         wr_data_1,
   input  logic [DATA_WIDTH-1:0]         wr_data_2,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   input  logic                          host_cs_n,
   input  logic                          host_sck,
   output logic                          host_miso,
   output logic                          host_miso_oe
);

   localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   state_t                    state;
   state_t                    state_nxt;

   logic [1:0]                cs_sync;
   logic [1:0]                sck_sync;
   logic                      cs_d;
   logic                      sck_d;
   logic                      cs_hi;
   logic                      cs_fall;
   logic                      sck_rise;
   logic                      sck_fall;

   meas_record_t              wr_rec;
   logic [RECORD_WIDTH-1:0]   fifo_head;
   logic                      fifo_empty;
   logic                      fifo_pop;

   logic [FRAME_BITS-1:0]     shreg;
   logic [BIT_CNT_W-1:0]      bit_cnt;
   logic                      valid_at_load;
   logic                      ovf_at_load;

   logic                      load_c;
   logic                      shift_en_c;
   logic                      commit_c;
   logic                      drop_c;

   logic [STATUS_LEVEL_W-1:0] level_sat;
   logic [STATUS_W-1:0]       status;
   logic [RECORD_WIDTH-1:0]   rec_field;
   logic [BASE_FRAME_BITS-1:0] frame_base;
   logic [FRAME_BITS-1:0]     frame;

   // Two-flop synchronizers plus an edge-detect stage; cs_n idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync  <= 2'b11;
         cs_d     <= 1'b1;
         sck_sync <= 2'b00;
         sck_d    <= 1'b0;
      end else begin
         cs_sync  <= {cs_sync[0], host_cs_n};
         cs_d     <= cs_sync[1];
         sck_sync <= {sck_sync[0], host_sck};
         sck_d    <= sck_sync[1];
      end
   end

   assign cs_hi    = cs_sync[1];
   assign cs_fall  = cs_d & ~cs_sync[1];
   assign sck_rise = ~sck_d & sck_sync[1];
   assign sck_fall = sck_d & ~sck_sync[1];

   assign wr_rec = '{tag: wr_tag, data_1: wr_data_1, data_2: wr_data_2};

   meas_fifo #(
      .WIDTH (RECORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_valid),
      .din   (wr_rec),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (full),
      .empty (fifo_empty),
      .level (level)
   );

   // Frame image as it would be loaded this cycle
   assign level_sat  = (32'(level) > 32'(STATUS_LEVEL_MAX)) ? STATUS_LEVEL_W'(STATUS_LEVEL_MAX)
                                                           : STATUS_LEVEL_W'(level);
   assign status     = {~fifo_empty, overflow, level_sat};
   assign rec_field  = fifo_empty ? '0 : fifo_head;
   assign frame_base = {status, rec_field};
`ifdef MEAS_READOUT_CRC8_EN
   assign frame      = {frame_base, crc8(frame_base)};
`else
   assign frame      = frame_base;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cs_fall) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (cs_hi) state_nxt = (bit_cnt == BIT_CNT_W'(FRAME_BITS)) ? COMMIT : IDLE;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_c     = 1'b0;
      shift_en_c = 1'b0;
      commit_c   = 1'b0;
      unique case (state)
         LOAD:    load_c     = 1'b1;
         SHIFT:   shift_en_c = ~cs_hi;
         COMMIT:  commit_c   = 1'b1;
         default: ;
      endcase
   end

   assign fifo_pop = commit_c & valid_at_load;
   assign drop_c   = wr_valid & full;

   // A drop in the commit cycle keeps overflow set even if it was reported
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop_c) begin
         overflow <= 1'b1;
      end else if (commit_c && ovf_at_load) begin
         overflow <= 1'b0;
      end
   end

   // Shift datapath: present on sck fall, count on sck rise, quiet whenever deselected
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg         <= '0;
         bit_cnt       <= '0;
         valid_at_load <= 1'b0;
         ovf_at_load   <= 1'b0;
         host_miso     <= 1'b0;
         host_miso_oe  <= 1'b0;
      end else if (load_c) begin
         shreg         <= frame;
         bit_cnt       <= '0;
         valid_at_load <= ~fifo_empty;
         ovf_at_load   <= overflow;
         host_miso     <= frame[FRAME_BITS-1];
         host_miso_oe  <= 1'b1;
      end else if (shift_en_c) begin
         if (sck_fall) begin
            shreg     <= {shreg[FRAME_BITS-2:0], 1'b0};
            host_miso <= shreg[FRAME_BITS-2];
         end
         if (sck_rise && (bit_cnt != '1)) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end else begin
         host_miso    <= 1'b0;
         host_miso_oe <= 1'b0;
      end
   end

endmodule
